// File: rtl/resp_outreg.sv
// Response output stage: merges add/shift pipe results into a 4-entry FIFO and replays them to the requester.
// Latency: result in cycle N appears on out_resp/out_data in cycle N+2 (empty FIFO); one response per 2 cycles max.
// Backpressure: resp_full (count >= FULL_MARK) stops upstream issue; pushes that find no slot are dropped and set ovf_err.
module resp_outreg #(
    parameter int DEPTH     = 4,
    parameter int FULL_MARK = 3
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        add_resp_vld,
    input  logic [0:1]  add_resp,
    input  logic [0:31] add_data,
    input  logic        shf_resp_vld,
    input  logic [0:1]  shf_resp,
    input  logic [0:31] shf_data,
    output logic [0:1]  out_resp,
    output logic [0:31] out_data,
    output logic        resp_full,
    output logic        ovf_err
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [2:0] MARK_C  = 3'(FULL_MARK);

    logic [33:0] mem [DEPTH];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    state_t      state;

    logic        add_push;
    logic        shf_push;
    logic        pop;
    logic        add_acc;
    logic        shf_acc;
    logic        drop;
    logic [2:0]  free_slots;

    always_comb begin
        add_push   = add_resp_vld && (add_resp != 2'b00);
        shf_push   = shf_resp_vld && (shf_resp != 2'b00);
        pop        = (state == IDLE) && (count != 3'd0);
        // The slot vacated by a same-edge pop is reusable: the head is read before it is overwritten.
        free_slots = DEPTH_C - count + 3'(pop);
        add_acc    = add_push && (free_slots != 3'd0);
        shf_acc    = shf_push && (free_slots > (add_acc ? 3'd1 : 3'd0));
        drop       = (add_push && !add_acc) || (shf_push && !shf_acc);
    end

    assign resp_full = (count >= MARK_C);

    // Add result takes the lower slot when both sources push together.
    always_ff @(posedge c_clk) begin
        if (add_acc) begin
            mem[wr_ptr] <= {add_resp, add_data};
        end
        if (shf_acc) begin
            mem[wr_ptr + 2'(add_acc)] <= {shf_resp, shf_data};
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            state    <= IDLE;
            out_resp <= 2'b00;
            out_data <= 32'd0;
            ovf_err  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + 2'(add_acc) + 2'(shf_acc);
            count  <= count + 3'(add_acc) + 3'(shf_acc) - 3'(pop);
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (drop) begin
                ovf_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        {out_resp, out_data} <= mem[rd_ptr];
                        state                <= SEND;
                    end
                end
                SEND: begin
                    // Clearing the outputs here guarantees the idle gap between responses.
                    out_resp <= 2'b00;
                    out_data <= 32'd0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_resp_outreg.sv
// Bench for resp_outreg: directed vector table, hand-written corner sequences and random traffic against a queue model.
module tb_resp_outreg;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        add_resp_vld;
    logic [0:1]  add_resp;
    logic [0:31] add_data;
    logic        shf_resp_vld;
    logic [0:1]  shf_resp;
    logic [0:31] shf_data;
    logic [0:1]  out_resp;
    logic [0:31] out_data;
    logic        resp_full;
    logic        ovf_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 c_clk = ~c_clk;

    resp_outreg #(.DEPTH(4), .FULL_MARK(3)) dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .add_resp_vld (add_resp_vld),
        .add_resp     (add_resp),
        .add_data     (add_data),
        .shf_resp_vld (shf_resp_vld),
        .shf_resp     (shf_resp),
        .shf_data     (shf_data),
        .out_resp     (out_resp),
        .out_data     (out_data),
        .resp_full    (resp_full),
        .ovf_err      (ovf_err)
    );

    // Reference model: a bounded queue of {resp, data} words plus the last driven response.
    logic [33:0] mq[$];
    logic [1:0]  m_resp;
    logic [31:0] m_data;
    bit          m_send;
    bit          m_ovf;

    task automatic model_reset();
        mq.delete();
        m_resp = 2'b00;
        m_data = 32'd0;
        m_send = 0;
        m_ovf  = 0;
    endtask

    task automatic model_edge();
        logic [33:0] head;
        logic [33:0] pushes[$];
        bit          do_pop;
        head   = '0;
        do_pop = !m_send && (mq.size() > 0);
        if (do_pop) head = mq.pop_front();
        if (add_resp_vld && add_resp != 2'b00) pushes.push_back({add_resp, add_data});
        if (shf_resp_vld && shf_resp != 2'b00) pushes.push_back({shf_resp, shf_data});
        foreach (pushes[i]) begin
            if (mq.size() < 4) mq.push_back(pushes[i]);
            else m_ovf = 1;
        end
        m_send = do_pop;
        m_resp = do_pop ? head[33:32] : 2'b00;
        m_data = do_pop ? head[31:0]  : 32'd0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input bit av, input logic [1:0] ar, input logic [31:0] ad,
                         input bit sv, input logic [1:0] sr, input logic [31:0] sd);
        add_resp_vld = av;
        add_resp     = ar;
        add_data     = ad;
        shf_resp_vld = sv;
        shf_resp     = sr;
        shf_data     = sd;
    endtask

    task automatic idle();
        drive(0, 2'b00, 32'd0, 0, 2'b00, 32'd0);
    endtask

    task automatic tick();
        @(posedge c_clk);
        if (reset) model_edge();
        #1;
        chk("model_resp", 32'(out_resp), 32'(m_resp));
        chk("model_data", out_data, m_data);
        chk("model_full", 32'(resp_full), 32'(mq.size() >= 3));
        chk("model_ovf",  32'(ovf_err), 32'(m_ovf));
    endtask

    typedef struct {
        bit          av;
        logic [1:0]  ar;
        logic [31:0] ad;
        bit          sv;
        logic [1:0]  sr;
        logic [31:0] sd;
        logic [1:0]  er;
        logic [31:0] ed;
        bit          ef;
        bit          eo;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input bit av, input logic [1:0] ar, input logic [31:0] ad,
                     input bit sv, input logic [1:0] sr, input logic [31:0] sd,
                     input logic [1:0] er, input logic [31:0] ed, input bit ef, input bit eo);
        vec_t r;
        r = '{av, ar, ad, sv, sr, sd, er, ed, ef, eo};
        tbl.push_back(r);
    endtask

    task automatic vi(input logic [1:0] er, input logic [31:0] ed, input bit ef, input bit eo);
        v(0, 2'b00, 32'd0, 0, 2'b00, 32'd0, er, ed, ef, eo);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        model_reset();

        // Single result: output two cycles later, for one cycle only.
        v(1, 2'b01, 32'h0000000A, 0, 2'b00, 32'd0, 2'b00, 32'd0, 0, 0);
        vi(2'b01, 32'h0000000A, 0, 0);
        vi(2'b00, 32'd0, 0, 0);
        vi(2'b00, 32'd0, 0, 0);
        // Simultaneous sources: add first, shift after a gap.
        v(1, 2'b01, 32'd12, 1, 2'b10, 32'hFFFFFFFF, 2'b00, 32'd0, 0, 0);
        vi(2'b01, 32'd12, 0, 0);
        vi(2'b00, 32'd0, 0, 0);
        vi(2'b10, 32'hFFFFFFFF, 0, 0);
        vi(2'b00, 32'd0, 0, 0);
        // Five back-to-back results: occupancy peaks at 3, nothing dropped.
        v(1, 2'b01, 32'd1, 0, 2'b00, 32'd0, 2'b00, 32'd0, 0, 0);
        v(1, 2'b01, 32'd2, 0, 2'b00, 32'd0, 2'b01, 32'd1, 0, 0);
        v(1, 2'b01, 32'd3, 0, 2'b00, 32'd0, 2'b00, 32'd0, 0, 0);
        v(1, 2'b01, 32'd4, 0, 2'b00, 32'd0, 2'b01, 32'd2, 0, 0);
        v(1, 2'b01, 32'd5, 0, 2'b00, 32'd0, 2'b00, 32'd0, 1, 0);
        vi(2'b01, 32'd3, 0, 0);
        vi(2'b00, 32'd0, 0, 0);
        vi(2'b01, 32'd4, 0, 0);
        vi(2'b00, 32'd0, 0, 0);
        vi(2'b01, 32'd5, 0, 0);
        vi(2'b00, 32'd0, 0, 0);
        // Valid with code 00 is ignored.
        v(0, 2'b00, 32'd0, 1, 2'b00, 32'h0000DEAD, 2'b00, 32'd0, 0, 0);
        v(1, 2'b00, 32'h0000BEEF, 1, 2'b00, 32'h0000DEAD, 2'b00, 32'd0, 0, 0);
        vi(2'b00, 32'd0, 0, 0);
        // Dual pushes overflow the FIFO; then a push into a full FIFO on a pop edge fits.
        v(1, 2'b01, 32'h11, 1, 2'b11, 32'h12, 2'b00, 32'd0, 0, 0);
        v(1, 2'b01, 32'h21, 1, 2'b10, 32'h22, 2'b01, 32'h11, 1, 0);
        v(1, 2'b01, 32'h31, 1, 2'b01, 32'h32, 2'b00, 32'd0, 1, 1);
        v(1, 2'b01, 32'h41, 0, 2'b00, 32'd0, 2'b11, 32'h12, 1, 1);
        vi(2'b00, 32'd0, 1, 1);
        vi(2'b01, 32'h21, 1, 1);
        vi(2'b00, 32'd0, 1, 1);
        vi(2'b10, 32'h22, 0, 1);
        vi(2'b00, 32'd0, 0, 1);
        vi(2'b01, 32'h31, 0, 1);
        vi(2'b00, 32'd0, 0, 1);
        vi(2'b01, 32'h41, 0, 1);
        vi(2'b00, 32'd0, 0, 1);

        #12;
        chk("rst_resp", 32'(out_resp), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_full", 32'(resp_full), 32'd0);
        chk("rst_ovf",  32'(ovf_err), 32'd0);
        #10 reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].sv, tbl[i].sr, tbl[i].sd);
            tick();
            chk($sformatf("vec%0d_resp", i), 32'(out_resp), 32'(tbl[i].er));
            chk($sformatf("vec%0d_data", i), out_data, tbl[i].ed);
            chk($sformatf("vec%0d_full", i), 32'(resp_full), 32'(tbl[i].ef));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf_err), 32'(tbl[i].eo));
        end

        // Reset clears the sticky overflow flag.
        idle();
        #2 reset = 1'b0;
        model_reset();
        #1 chk("ovf_clr", 32'(ovf_err), 32'd0);
        #4 reset = 1'b1;

        // Wrap-around: ten results at one per two cycles.
        for (int k = 1; k <= 10; k++) begin
            drive(1, 2'b01, 32'(k), 0, 2'b00, 32'd0);
            tick();
            chk("wrap_gap", 32'(out_resp), 32'd0);
            idle();
            tick();
            chk("wrap_resp", 32'(out_resp), 32'd1);
            chk("wrap_data", out_data, 32'(k));
            chk("wrap_full", 32'(resp_full), 32'd0);
            chk("wrap_ovf",  32'(ovf_err), 32'd0);
        end

        // Reset during a SEND cycle with entries queued.
        drive(1, 2'b01, 32'h51, 1, 2'b01, 32'h52);
        tick();
        drive(1, 2'b10, 32'h53, 0, 2'b00, 32'd0);
        tick();
        chk("mid_send", 32'(out_resp), 32'd1);
        idle();
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_resp", 32'(out_resp), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_full", 32'(resp_full), 32'd0);
        chk("mid_rst_ovf",  32'(ovf_err), 32'd0);
        #3 reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_quiet", 32'(out_resp), 32'd0);
        end
        drive(1, 2'b11, 32'h61, 0, 2'b00, 32'd0);
        tick();
        idle();
        tick();
        chk("post_rst_new", out_data, 32'h61);

        // Random traffic: heavy phase overflows, light phase drains.
        for (int i = 0; i < 600; i++) begin
            int pct;
            pct = (i < 300) ? 70 : 20;
            drive($urandom_range(0, 99) < pct, 2'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 99) < pct, 2'($urandom_range(0, 3)), $urandom);
            tick();
        end
        idle();
        for (int i = 0; i < 10; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
